// File: rtl/hough_frame_sequencer.sv
// hough_frame_sequencer
//   Per-frame controller for the Hough core. On an accepted vsync it pulses
//   hough_frame_start and waits out the accumulator clear. It then forwards
//   edge pixels to the core with one cycle of latency until the last pixel of
//   the frame is seen. Next it waits out the peak scan. Detected lines go into
//   a small show-ahead FIFO for downstream readout.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   enable, vsync            frame acceptance (enable sampled only when idle)
//   pix_valid/edge/x/y       edge-pixel stream from the Sobel stage
//   hough_frame_start        one-cycle start to the core
//   hough_pixel_valid/in/x/y gated, registered pixel stream to the core
//   line_valid/rho/theta/votes  peak results from the core
//   res_valid/ready/rho/theta/votes  FIFO head, popped on valid & ready
//   res_overflow             sticky per frame: a line was lost to a full FIFO
//   busy, frame_done         status; frame_done pulses in the last scan cycle
//   frames_dropped           saturating count of vsyncs ignored while busy
module hough_frame_sequencer #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int CLEAR_CYCLES = 30000,
  parameter int SCAN_CYCLES  = 30000,
  parameter int MAX_LINES    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        vsync,
  input  logic        pix_valid,
  input  logic        pix_edge,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic        hough_frame_start,
  output logic        hough_pixel_valid,
  output logic        hough_pixel_in,
  output logic [9:0]  hough_pixel_x,
  output logic [9:0]  hough_pixel_y,
  input  logic        line_valid,
  input  logic [15:0] line_rho,
  input  logic [7:0]  line_theta,
  input  logic [11:0] line_votes,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_rho,
  output logic [7:0]  res_theta,
  output logic [11:0] res_votes,
  output logic        res_overflow,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frames_dropped
);

  localparam int CNT_MAX = (CLEAR_CYCLES > SCAN_CYCLES) ? CLEAR_CYCLES : SCAN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int AW      = $clog2(MAX_LINES);
  localparam int STAGES  = 1;  // pixel forwarding latency

  localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] SCN_LOAD = CW'(SCAN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, VOTE, SCAN} state_t;

  typedef struct packed {
    logic [15:0] rho;
    logic [7:0]  theta;
    logic [11:0] votes;
  } line_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [STAGES-1:0] vld_pipe;

  logic start_frame, accept, last_pix;

  assign start_frame = (state == IDLE) && vsync && enable;
  assign accept      = (state == VOTE) && pix_valid;
  assign last_pix    = (pix_x == 10'(IMG_WIDTH - 1)) && (pix_y == 10'(IMG_HEIGHT - 1));

  assign busy              = (state != IDLE);
  assign hough_pixel_valid = vld_pipe[STAGES-1];

  // Frame FSM, pixel forwarding and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      hough_frame_start <= 1'b0;
      frame_done        <= 1'b0;
      frames_dropped    <= '0;
      vld_pipe          <= '0;
      hough_pixel_in    <= 1'b0;
      hough_pixel_x     <= '0;
      hough_pixel_y     <= '0;
    end else begin
      hough_frame_start <= start_frame;
      frame_done        <= 1'b0;

      if (vsync && (state != IDLE) && (frames_dropped != 8'hFF))
        frames_dropped <= frames_dropped + 8'd1;

      vld_pipe[0] <= accept;
      for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];

      // Hold the pixel bus steady between accepted pixels
      if (accept) begin
        hough_pixel_in <= pix_edge;
        hough_pixel_x  <= pix_x;
        hough_pixel_y  <= pix_y;
      end

      case (state)
        IDLE: begin
          if (start_frame) begin
            state <= CLEAR;
            cnt   <= CLR_LOAD;
          end
        end
        CLEAR: begin
          if (cnt == '0) state <= VOTE;
          else           cnt   <= cnt - CW'(1);
        end
        VOTE: begin
          if (accept && last_pix) begin
            state      <= SCAN;
            cnt        <= SCN_LOAD;
            frame_done <= (SCAN_CYCLES == 1);
          end
        end
        SCAN: begin
          // frame_done is registered, so raise it one cycle ahead of cnt==0
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt        <= cnt - CW'(1);
            frame_done <= (cnt == CW'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result FIFO (show-ahead)
  line_t         mem [MAX_LINES];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push;
  line_t         head, din;

  assign full = (count == (AW+1)'(MAX_LINES));
  assign res_valid = (count != '0);
  assign pop  = res_valid && res_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push = line_valid && (!full || pop);
  assign din  = '{rho: line_rho, theta: line_theta, votes: line_votes};
  assign head = mem[rd_ptr];

  assign res_rho   = res_valid ? head.rho   : '0;
  assign res_theta = res_valid ? head.theta : '0;
  assign res_votes = res_valid ? head.votes : '0;

  always_ff @(posedge clk) begin
    if (rst || start_frame) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      res_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (line_valid && full && !pop) res_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !start_frame) mem[wr_ptr] <= din;
  end

endmodule

// File: tb/tb_hough_frame_sequencer.sv
module tb_hough_frame_sequencer;
  localparam int W = 8, H = 4, CLR = 16, SCN = 32, ML = 4;

  logic        clk = 0, rst = 1, enable = 0, vsync = 0;
  logic        pix_valid = 0, pix_edge = 0;
  logic [9:0]  pix_x = 0, pix_y = 0;
  logic        line_valid = 0, res_ready = 0;
  logic [15:0] line_rho = 0;
  logic [7:0]  line_theta = 0;
  logic [11:0] line_votes = 0;

  logic        hough_frame_start, hough_pixel_valid, hough_pixel_in;
  logic [9:0]  hough_pixel_x, hough_pixel_y;
  logic        res_valid, res_overflow, busy, frame_done;
  logic [15:0] res_rho;
  logic [7:0]  res_theta;
  logic [11:0] res_votes;
  logic [7:0]  frames_dropped;

  hough_frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CLEAR_CYCLES(CLR),
                          .SCAN_CYCLES(SCN), .MAX_LINES(ML)) dut (
    .clk(clk), .rst(rst), .enable(enable), .vsync(vsync),
    .pix_valid(pix_valid), .pix_edge(pix_edge), .pix_x(pix_x), .pix_y(pix_y),
    .hough_frame_start(hough_frame_start), .hough_pixel_valid(hough_pixel_valid),
    .hough_pixel_in(hough_pixel_in), .hough_pixel_x(hough_pixel_x), .hough_pixel_y(hough_pixel_y),
    .line_valid(line_valid), .line_rho(line_rho), .line_theta(line_theta), .line_votes(line_votes),
    .res_valid(res_valid), .res_ready(res_ready), .res_rho(res_rho), .res_theta(res_theta),
    .res_votes(res_votes), .res_overflow(res_overflow), .busy(busy), .frame_done(frame_done),
    .frames_dropped(frames_dropped));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  logic [35:0] tbl [5] = '{36'h1111010A1, 36'h2222020B2, 36'h3333030C3,
                           36'h4444040D4, 36'h5555050E5};

  // Model: a frame is described by the cycle frame_start appears (t_start)
  // and the cycle its scan finishes (t_end); everything else follows from
  // where a cycle falls relative to those stamps.
  int          cyc = 0;
  int          t_start = -1, t_end = -1;
  bit          m_start = 0, m_done = 0, m_pv = 0, m_pe = 0, m_ovf = 0;
  logic [9:0]  m_px = 0, m_py = 0;
  logic [35:0] q[$];
  int          m_drop = 0;

  function automatic bit act_at(int x);
    return (t_start >= 0) && (x >= t_start) && (t_end < 0 || x <= t_end);
  endfunction

  initial forever begin
    int c;
    bit pop, push, full;
    @(posedge clk);
    c = cyc;
    cyc++;
    m_pv = 0;
    if (rst) begin
      t_start = -1; t_end = -1; q.delete(); m_ovf = 0; m_drop = 0;
    end else begin
      pop  = (q.size() > 0) && res_ready;
      full = (q.size() == ML);
      push = line_valid && (!full || pop);
      if (!act_at(c) && vsync && enable) begin
        t_start = cyc; t_end = -1; q.delete(); m_ovf = 0;
      end else begin
        if (act_at(c)) begin
          if (vsync && m_drop < 255) m_drop++;
          if (c >= t_start + CLR && t_end < 0 && pix_valid) begin
            m_pv = 1; m_pe = pix_edge; m_px = pix_x; m_py = pix_y;
            if (pix_x == W-1 && pix_y == H-1) t_end = c + SCN;
          end
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back({line_rho, line_theta, line_votes});
        if (line_valid && full && !pop) m_ovf = 1;
      end
    end
    m_start = (t_start == cyc);
    m_done  = (t_end >= 0) && (t_end == cyc);
  end

  // Observed event stamps for the literal latency checks
  int t_fs_obs = -1, first_pv = -1, pv_cnt = 0, t_done_obs = -1;

  initial forever begin
    @(posedge clk);
    #1;
    check("busy", busy, act_at(cyc));
    check("frame_start", hough_frame_start, m_start);
    check("frame_done", frame_done, m_done);
    check("pix_valid", hough_pixel_valid, m_pv);
    if (m_pv) check("pix_data", {hough_pixel_in, hough_pixel_x, hough_pixel_y}, {m_pe, m_px, m_py});
    check("res_valid", res_valid, q.size() > 0);
    if (q.size() > 0) check("res_head", {res_rho, res_theta, res_votes}, q[0]);
    else              check("res_idle", {res_rho, res_theta, res_votes}, 36'h0);
    check("res_overflow", res_overflow, m_ovf);
    check("frames_dropped", frames_dropped, m_drop);
    if (hough_frame_start) t_fs_obs = cyc;
    if (hough_pixel_valid) begin
      pv_cnt++;
      if (first_pv < 0) first_pv = cyc;
    end
    if (frame_done) t_done_obs = cyc;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_line(input int i);
    {line_rho, line_theta, line_votes} = tbl[i];
  endtask

  initial begin
    int t_last, k;
    repeat (3) tick();
    rst = 0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_dropped", frames_dropped, 0);

    // vsync with enable low is ignored entirely
    vsync = 1; tick(); vsync = 0; tick();
    check("noen_busy", busy, 0);
    check("noen_dropped", frames_dropped, 0);

    // Frame 1: pixels during clear (including the last-pixel coordinate) are discarded
    enable = 1; vsync = 1; tick(); vsync = 0;
    check("f1_start", hough_frame_start, 1);
    for (int i = 0; i < CLR; i++) begin
      pix_valid = 1; pix_x = 7; pix_y = 3; pix_edge = 1; tick();
    end
    for (int i = 0; i < W*H; i++) begin
      if (i % 9 == 4) begin pix_valid = 0; vsync = 0; tick(); end
      pix_valid = 1; pix_x = 10'(i % W); pix_y = 10'(i / W);
      pix_edge = ((i % 3) == 0);
      vsync = (i == 5 || i == 12);
      t_last = cyc;
      tick();
    end
    pix_valid = 0; vsync = 0;
    check("f1_pix_count", pv_cnt, 32);
    check("f1_first_pix_latency", first_pv - t_fs_obs, 17);
    check("f1_dropped", frames_dropped, 2);

    // Five lines into a 4-deep FIFO with nobody reading
    t_done_obs = -1;
    for (int i = 0; i < 5; i++) begin line_valid = 1; drive_line(i); tick(); end
    line_valid = 0;
    k = 0;
    while (t_done_obs < 0 && k < 100) begin tick(); k++; end
    check("f1_done_latency", t_done_obs - t_last, 32);
    tick();
    check("f1_busy_after", busy, 0);
    check("f1_overflow", res_overflow, 1);
    res_ready = 1;
    for (int i = 0; i < ML; i++) begin
      check($sformatf("f1_pop%0d", i), {res_rho, res_theta, res_votes}, tbl[i]);
      tick();
    end
    tick();  // pop while empty
    check("f1_empty", res_valid, 0);
    res_ready = 0;

    // Frame 2: flush beats same-cycle push; full FIFO push+pop keeps no overflow
    line_valid = 1; drive_line(4); res_ready = 1; vsync = 1; tick();
    vsync = 0; line_valid = 0; res_ready = 0;
    check("f2_flush", res_valid, 0);
    check("f2_ovf_clr", res_overflow, 0);
    for (int i = 0; i < ML; i++) begin line_valid = 1; drive_line(i); tick(); end
    drive_line(4); res_ready = 1; tick();
    line_valid = 0; res_ready = 0;
    check("f2_pushpop_ovf", res_overflow, 0);
    check("f2_pushpop_head", {res_rho, res_theta, res_votes}, tbl[1]);
    repeat (11) tick();
    pix_valid = 1; pix_x = 7; pix_y = 3; t_last = cyc; tick();
    pix_valid = 0;
    repeat (31) tick();
    check("f2_done_cycle", frame_done, 1);
    vsync = 1; tick(); vsync = 0;
    check("f2_end_vsync_busy", busy, 0);
    check("f2_end_vsync_dropped", frames_dropped, 3);
    check("f2_end_vsync_nostart", hough_frame_start, 0);
    tick();
    check("f2_still_idle", busy, 0);

    // Frame 3: reset in the middle of VOTE
    vsync = 1; tick(); vsync = 0;
    repeat (CLR) tick();
    pix_valid = 1; pix_x = 0; pix_y = 0; line_valid = 1; drive_line(2); tick();
    line_valid = 0; pix_x = 1; tick();
    rst = 1; pix_x = 2; tick();
    rst = 0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pv", hough_pixel_valid, 0);
    check("rst_mid_fifo", res_valid, 0);
    check("rst_mid_dropped", frames_dropped, 0);
    check("rst_mid_pixbus", {hough_pixel_in, hough_pixel_x, hough_pixel_y}, 21'h0);
    check("rst_mid_flags", {hough_frame_start, frame_done, res_overflow}, 3'b000);
    pix_x = 7; pix_y = 3;
    repeat (3) tick();
    pix_valid = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
